// File: rtl/i2c_byte_write_master.sv
// Single-master I2C byte writer: one [START][addr<<1|0][DATA][STOP] per request.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           one-cycle request, accepted only while idle
//   dev_addr, wdata 7-bit target address and data byte, latched on accept
//   busy            high from the cycle after accept until the transaction ends
//   done            one-cycle pulse at transaction end
//   ack_error       status of the last transaction (1 = a NACK was seen)
//   scl             push-pull I2C clock (no clock stretching)
//   sda             open-drain I2C data (driven to 0 or released)
module i2c_byte_write_master #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned I2C_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    inout  wire        sda
);

    // Clocks per SCL quarter period; must be at least 8.
    localparam int unsigned QTR = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned QW  = $clog2(QTR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    qidx, qidx_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    addr_byte, addr_byte_n;
    logic [7:0]    data_byte, data_byte_n;
    logic          busy_n, done_n, ack_error_n, scl_n;
    logic          sda_low, sda_low_n;
    logic          tick;
    logic          cur_bit;

    assign sda = sda_low ? 1'b0 : 1'bz;

    // State, timer and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            qcnt      <= '0;
            qidx      <= '0;
            bitcnt    <= '0;
            addr_byte <= '0;
            data_byte <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            scl       <= 1'b1;
            sda_low   <= 1'b0;
        end else begin
            state     <= state_n;
            qcnt      <= qcnt_n;
            qidx      <= qidx_n;
            bitcnt    <= bitcnt_n;
            addr_byte <= addr_byte_n;
            data_byte <= data_byte_n;
            busy      <= busy_n;
            done      <= done_n;
            ack_error <= ack_error_n;
            scl       <= scl_n;
            sda_low   <= sda_low_n;
        end
    end

    // Next-state logic; bus outputs are decoded from the next state so they
    // line up with the registered state/quarter on the same cycle.
    always_comb begin
        state_n     = state;
        qcnt_n      = qcnt;
        qidx_n      = qidx;
        bitcnt_n    = bitcnt;
        addr_byte_n = addr_byte;
        data_byte_n = data_byte;
        busy_n      = busy;
        done_n      = 1'b0;
        ack_error_n = ack_error;
        scl_n       = 1'b1;
        sda_low_n   = 1'b0;
        cur_bit     = 1'b1;
        tick        = (qcnt == QW'(QTR - 1));

        if (state != S_IDLE) begin
            qcnt_n = tick ? '0 : qcnt + QW'(1);
            if (tick) begin
                qidx_n = qidx + 2'd1;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_START;
                    addr_byte_n = {dev_addr, 1'b0};
                    data_byte_n = wdata;
                    busy_n      = 1'b1;
                    ack_error_n = 1'b0;
                    qcnt_n      = '0;
                    qidx_n      = '0;
                    bitcnt_n    = 3'd7;
                end
            end
            S_START: begin
                if (tick && qidx == 2'd1) begin
                    state_n = S_ADDR;
                    qidx_n  = '0;
                end
            end
            S_ADDR, S_DATA: begin
                if (tick && qidx == 2'd3) begin
                    if (bitcnt == 3'd0) begin
                        state_n  = (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                        bitcnt_n = 3'd7;
                    end else begin
                        bitcnt_n = bitcnt - 3'd1;
                    end
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                // ack_error was cleared on accept, so it holds this transfer's NACK.
                if (tick && qidx == 2'd2 && sda) begin
                    ack_error_n = 1'b1;
                end
                if (tick && qidx == 2'd3) begin
                    state_n = (state == S_ADDR_ACK && !ack_error) ? S_DATA : S_STOP;
                end
            end
            S_STOP: begin
                if (tick && qidx == 2'd2) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    qcnt_n  = '0;
                    qidx_n  = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        case (state_n)
            S_START: begin
                sda_low_n = (qidx_n == 2'd1);
            end
            S_ADDR, S_DATA: begin
                cur_bit   = (state_n == S_ADDR) ? addr_byte_n[bitcnt_n] : data_byte_n[bitcnt_n];
                scl_n     = qidx_n[1];
                sda_low_n = ~cur_bit;
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_n = qidx_n[1];
            end
            S_STOP: begin
                scl_n     = (qidx_n != 2'd0);
                sda_low_n = (qidx_n != 2'd2);
            end
            default: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_write_master.sv
// Bench for i2c_byte_write_master: quarter-level bus model, behavioural slave
// at 7'h55 with an LED register, and directed transactions.
module tb_i2c_byte_write_master;

    localparam int unsigned CLK_FREQ = 4_000_000;
    localparam int unsigned I2C_FREQ = 100_000;
    localparam int QTR     = 10;
    localparam int FULL_Q  = 77;
    localparam int SHORT_Q = 41;
    localparam logic [6:0] SLAVE_ADDR = 7'h55;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, ack_error, scl;
    wire        sda;
    logic       s_drive = 1'b0;

    pullup(sda);
    assign sda = s_drive ? 1'b0 : 1'bz;

    i2c_byte_write_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dev_addr(dev_addr), .wdata(wdata),
        .busy(busy), .done(done), .ack_error(ack_error), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave: address 0x55, LED register on data ACK ----------------
    bit         nack_data = 1'b0;
    logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1;
    bit         s_in = 1'b0, s_ack = 1'b0, s_bus = 1'b0, ack_v;
    int         s_cnt = 0, s_byte = 0;
    logic [7:0] s_shift = '0;
    logic [7:0] led = '0;
    int         n_start = 0, n_stop = 0, n_rise = 0, n_done = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        if (s_prev_scl && scl && s_prev_sda && !sda) begin
            s_in <= 1'b1; s_bus <= 1'b1; s_cnt <= 0; s_byte <= 0;
            n_start <= n_start + 1; n_rise <= 0;
        end else if (s_prev_scl && scl && !s_prev_sda && sda) begin
            s_in <= 1'b0; s_bus <= 1'b0; s_drive <= 1'b0; n_stop <= n_stop + 1;
        end else if (!s_prev_scl && scl) begin
            if (s_bus) n_rise <= n_rise + 1;
            if (s_in) begin
                if (s_cnt < 8) s_shift <= {s_shift[6:0], sda};
                s_cnt <= s_cnt + 1;
            end
        end else if (s_in && s_prev_scl && !scl) begin
            if (s_cnt == 8) begin
                rx_q.push_back(s_shift);
                ack_v = (s_byte == 0) ? (s_shift[7:1] == SLAVE_ADDR && !s_shift[0]) : !nack_data;
                if (ack_v && s_byte == 1) led <= s_shift;
                s_drive <= ack_v;
                s_ack   <= ack_v;
            end else if (s_cnt == 9) begin
                s_drive <= 1'b0; s_cnt <= 0; s_byte <= s_byte + 1;
                if (!s_ack) s_in <= 1'b0;
            end
        end
        s_prev_scl <= scl;
        s_prev_sda <= sda;
    end

    always @(negedge clk) if (rst_n && done) n_done <= n_done + 1;

    // ---------------- transaction model ----------------
    // {scl, master drives 0, ACK quarter} for quarter k of a transaction.
    function automatic logic [2:0] qpat(input int k, input logic [7:0] ab, input logic [7:0] db, input bit shrt);
        int nb, b, p;
        logic sclv, bv;
        nb = shrt ? 9 : 18;
        if (k == 0) return 3'b100;
        if (k == 1) return 3'b110;
        k = k - 2;
        if (k < nb * 4) begin
            b = k / 4; p = k % 4; sclv = (p >= 2);
            if (b == 8 || b == 17) return {sclv, 2'b01};
            bv = (b < 8) ? ab[7 - b] : db[16 - b];
            return {sclv, ~bv, 1'b0};
        end
        k = k - nb * 4;
        if (k == 0) return 3'b010;
        if (k == 1) return 3'b110;
        return 3'b100;
    endfunction

    bit         m_active = 0, m_done = 0, m_ackerr = 0, m_short = 0, m_nack = 0;
    int         m_t = 0, m_len = 0, m_nack_t = 0;
    logic [7:0] m_ab = '0, m_db = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_done <= 0; m_ackerr <= 0; m_t <= 0;
        end else begin
            m_done <= 0;
            if (m_active) begin
                m_t <= m_t + 1;
                if (m_nack && m_t + 1 == m_nack_t) m_ackerr <= 1;
                if (m_t + 1 == m_len * QTR) begin
                    m_active <= 0; m_done <= 1;
                end
            end else if (start) begin
                m_active <= 1; m_t <= 0; m_ackerr <= 0;
                m_ab <= {dev_addr, 1'b0}; m_db <= wdata;
                // NACK becomes visible after the ACK bit's third quarter.
                if (dev_addr != SLAVE_ADDR) begin
                    m_short <= 1; m_nack <= 1; m_len <= SHORT_Q; m_nack_t <= (2 + 32 + 3) * QTR;
                end else begin
                    m_short <= 0; m_nack <= nack_data; m_len <= FULL_Q; m_nack_t <= (2 + 36 + 32 + 3) * QTR;
                end
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin : cmp
        int k;
        logic [2:0] pat, pp;
        if (!rst_n) begin
            check("rst_scl", scl, 1); check("rst_sda", sda, 1);
            check("rst_busy", busy, 0); check("rst_done", done, 0);
        end else if (m_active) begin
            k   = m_t / QTR;
            pat = qpat(k, m_ab, m_db, m_short);
            pp  = (k > 0) ? qpat(k - 1, m_ab, m_db, m_short) : 3'b000;
            check("scl", scl, pat[2]);
            if (pat[1]) check("sda_low", sda, 0);
            else if (!pat[0] && !(m_t % QTR < 2 && pp[0])) check("sda_rel", sda, 1);
            check("busy", busy, 1);
            check("done", done, 0);
            check("ack_error", ack_error, m_ackerr);
        end else begin
            check("idle_scl", scl, 1);
            if (!s_drive) check("idle_sda", sda, 1);
            check("idle_busy", busy, 0);
            check("idle_done", done, m_done);
            check("idle_ack_error", ack_error, m_ackerr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [6:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        start = 1'b1; dev_addr = a; wdata = d;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high; lat counts cycles from busy rise.
    task automatic wait_done(output int lat);
        bit seen;
        seen = 0; lat = 0;
        while (!seen && lat < 5000) begin
            @(negedge clk);
            if (done) seen = 1;
            else lat++;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ns, nd, lim;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_scl", scl, 1); check("reset_sda", sda, 1);
        check("reset_busy", busy, 0); check("reset_done", done, 0);
        check("reset_ack_error", ack_error, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Full ACKed write to the LED slave.
        rx_q.delete(); ns = n_stop;
        launch(7'h55, 8'hA5); wait_done(lat);
        check("t1_latency", lat, 770);
        check("t1_ack_error", ack_error, 0);
        check("t1_nbytes", rx_q.size(), 2);
        check("t1_addr_byte", rx_q[0], 8'hAA);
        check("t1_data_byte", rx_q[1], 8'hA5);
        check("t1_led", led, 8'hA5);
        check("t1_scl_rises", n_rise, 19);
        check("t1_stop", n_stop - ns, 1);
        repeat (5) @(posedge clk);

        // Address NACK: nobody at 0x54.
        rx_q.delete(); ns = n_stop;
        launch(7'h54, 8'h77); wait_done(lat);
        check("t2_latency", lat, 410);
        check("t2_ack_error", ack_error, 1);
        check("t2_nbytes", rx_q.size(), 1);
        check("t2_addr_byte", rx_q[0], 8'hA8);
        check("t2_scl_rises", n_rise, 10);
        check("t2_stop", n_stop - ns, 1);
        check("t2_led", led, 8'hA5);
        repeat (5) @(posedge clk);

        // Address ACK, data NACK.
        rx_q.delete(); nack_data = 1'b1;
        launch(7'h55, 8'h3C); wait_done(lat);
        check("t3_latency", lat, 770);
        check("t3_ack_error", ack_error, 1);
        check("t3_data_byte", rx_q[1], 8'h3C);
        check("t3_scl_rises", n_rise, 19);
        check("t3_led", led, 8'hA5);
        nack_data = 1'b0;
        repeat (5) @(posedge clk);

        // start pulsed mid-transfer is ignored.
        rx_q.delete(); nd = n_done;
        launch(7'h55, 8'h5A);
        repeat (100) @(posedge clk);
        launch(7'h12, 8'hFF);
        wait_done(lat);
        repeat (50) @(posedge clk);
        check("t4_done_pulses", n_done - nd, 1);
        check("t4_nbytes", rx_q.size(), 2);
        check("t4_data_byte", rx_q[1], 8'h5A);
        check("t4_led", led, 8'h5A);
        check("t4_busy_after", busy, 0);

        // Reset during DATA bit 3 (quarter 54), then a fresh write.
        launch(7'h55, 8'hC3);
        lim = 0;
        while (m_t < 54 * QTR + 3 && lim < 2000) begin
            @(negedge clk); lim++;
        end
        check("t5_reached_bit3", m_t >= 54 * QTR + 3, 1);
        check("t5_scl_low_before", scl, 0);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_scl", scl, 1);
        check("t5_rst_sda", sda, 1);
        check("t5_rst_busy", busy, 0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        rx_q.delete();
        launch(7'h55, 8'h0F); wait_done(lat);
        check("t5_latency", lat, 770);
        check("t5_ack_error", ack_error, 0);
        check("t5_led", led, 8'h0F);
        repeat (5) @(posedge clk);

        // Back-to-back: second start is high during the done cycle.
        rx_q.delete(); nd = n_done; ns = n_start;
        launch(7'h55, 8'h11); wait_done(lat);
        start = 1'b1; dev_addr = 7'h55; wdata = 8'h22;
        @(posedge clk); #2;
        start = 1'b0;
        check("t6_busy_again", busy, 1);
        wait_done(lat);
        check("t6_latency2", lat, 770);
        repeat (20) @(posedge clk);
        check("t6_done_pulses", n_done - nd, 2);
        check("t6_starts", n_start - ns, 2);
        check("t6_nbytes", rx_q.size(), 4);
        check("t6_first_data", rx_q[1], 8'h11);
        check("t6_second_addr", rx_q[2], 8'hAA);
        check("t6_led", led, 8'h22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_byte_write_master.md
Name: i2c_byte_write_master

Overview:
- Single-master I2C controller that performs one complete write transaction, [START][addr<<1|0][DATA][STOP], per request.
- Sits directly upstream of the bus slaves (LED slave at 0x55, and others) and is driven by the board-level control logic.
- Generates SCL as a push-pull output and drives SDA open-drain.
- Reports ACK/NACK status for each transaction.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, SCL frequency in Hz.
- QTR (derived localparam), CLK_FREQ/(4*I2C_FREQ) = 250, clocks per SCL quarter-period. Must be ≥ 8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; accepted only when busy=0
- dev_addr  input  7  target 7-bit address; latched on accept
- wdata  input  8  data byte; latched on accept
- busy  output  1  high from the cycle after accept until transaction end
- done  output  1  one-cycle pulse at transaction end
- ack_error  output  1  status of the last transaction; 1 = a NACK was seen
- scl  output  1  I2C clock, push-pull; no clock stretching supported
- sda  inout  1  I2C data; driven only to 0, otherwise released to Z

Behaviour:
- Reset (async): state=IDLE, scl=1, sda released (Z), busy=0, done=0, ack_error=0, quarter counter=0, bit counter=0.
- Reset asserted mid-transfer: bus is released immediately. No STOP is generated.
- Quarter timer: counts 0..QTR-1 while not IDLE. The tick at QTR-1 advances the quarter index (0..3) and restarts the counter.
- Accept: start=1 && state==IDLE latches addr_byte={dev_addr,1'b0} and wdata. Next cycle: busy=1, state=START, ack_error cleared to 0.
- start while busy=1 is ignored. No queueing.
- START (2 quarters):
  - q0: scl=1, sda released.
  - q1: scl=1, sda=0.
- ADDR, DATA (8 bits each, MSB first), 4 quarters per bit:
  - q0: scl=0, SDA set to bit (0 → drive 0, 1 → release).
  - q1: scl=0.
  - q2: scl=1.
  - q3: scl=1.
  - SDA changes only in q0, while SCL is low.
- ADDR_ACK, DATA_ACK (1 bit, 4 quarters): same SCL pattern, SDA released in q0. SDA is sampled on the last clk of q2; 0 = ACK.
- Transitions:
  - IDLE→START on accept.
  - START→ADDR.
  - ADDR→ADDR_ACK after bit 0.
  - ADDR_ACK: ACK→DATA; NACK→set ack_error=1, go to STOP (data byte not sent).
  - DATA→DATA_ACK after bit 0.
  - DATA_ACK: NACK sets ack_error=1; either outcome goes to STOP.
  - STOP→IDLE.
- STOP (3 quarters):
  - q0: scl=0, sda=0.
  - q1: scl=1, sda=0.
  - q2: scl=1, sda released. SDA rises with SCL high.
- End of transaction: on the cycle after the final STOP quarter tick, done=1 for one cycle, busy=0, state=IDLE. ack_error holds until the next accept.
- Latency (full ACKed transfer): 2+72+3 = 77 quarters = 77*QTR clocks (19250 at defaults) from the busy rise to the done pulse.
- Latency (address NACK): 2+36+3 = 41 quarters.
- SCL pulses per transaction: 18 (ACKed) or 9 (address NACK), plus the STOP rising edge.
- SDA never changes while SCL=1 except at the START and STOP edges.
- A new start is accepted on the cycle done pulses or later (state==IDLE).

Test Plan:
- Write addr 0x55 data 0xA5 with i2c_led_slave attached → SDA bits on SCL rise are 0xAA, ACK, 0xA5, ACK. STOP seen. done after 19250 clocks. ack_error=0. LED=0xA5.
- Write addr 0x54 (no slave present, pull-up only) → NACK at bit 9, ack_error=1. Exactly 9 SCL high pulses before the STOP. done after 41*QTR clocks. LED unchanged.
- Bus model ACKs the address and NACKs the data, data 0x3C → all 18 bits clocked, ack_error=1, STOP generated, done pulses.
- start pulsed again mid-transfer with different addr/data → ignored. Bus bytes match the first request. Only one done pulse.
- rst_n asserted during DATA bit 3 → scl=1 and sda=Z within the same cycle, busy=0. A fresh write 0x55/0x0F after release completes and sets LED=0x0F.
- Back-to-back: start asserted the cycle done pulses → accepted. Second transaction starts with a valid START. Both done pulses observed.
